run_step_controller: RTL and testbench

- Generates the slow CPU clock and owns when the CPU advances.
- Modes:
  - Free-run at a switch-selected rate, pausable by button.
  - Single-step: one CPU clock pulse per debounced button press.
- Sits between the physical button/switch inputs and the cpu/light_dimmer instances.
- Guarantees full-width clock phases: no runt pulses on any mode, rate or pause change.

---
 rtl/run_step_pkg.sv | 25 ++
 rtl/run_step_controller_if.sv | 37 +++
 rtl/button_debouncer.sv | 52 +++++
 rtl/run_step_controller.sv | 150 +++++++++++++++
 tb/tb_run_step_controller.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/run_step_pkg.sv
// Shared types and helpers for the run/step CPU clock controller.
package run_step_pkg;

    localparam int unsigned COUNT_W = 32;
    localparam int unsigned TICK_W  = 16;
    localparam int unsigned RATE_W  = 4;

    typedef enum logic [1:0] {
        RUN_LO,
        RUN_HI,
        HALT,
        STEP_HI
    } state_t;

    // Free-run half period for a rate exponent, never below one cycle.
    function automatic logic [COUNT_W-1:0] half_period(
        input logic [COUNT_W-1:0] clock_hz,
        input logic [RATE_W-1:0]  rate
    );
        logic [COUNT_W-1:0] h;
        h = (clock_hz >> rate) >> 1;
        return (h == '0) ? COUNT_W'(1) : h;
    endfunction

endpackage

// File: rtl/run_step_controller_if.sv
// Button/switch inputs and CPU clock outputs of the run/step controller.
// STEP_LIMIT_EN adds the TICK_LIMIT input.
interface run_step_controller_if;
    import run_step_pkg::*;

    logic              BUTTON;
    logic              STEP_MODE;
    logic [RATE_W-1:0] RATE;
    logic              SLOW_CLOCK;
    logic              TICK;
    logic              HALTED;
    logic [TICK_W-1:0] TICK_COUNT;
`ifdef STEP_LIMIT_EN
    logic [TICK_W-1:0] TICK_LIMIT;

    modport master (
        output BUTTON, STEP_MODE, RATE, TICK_LIMIT,
        input  SLOW_CLOCK, TICK, HALTED, TICK_COUNT
    );

    modport slave (
        input  BUTTON, STEP_MODE, RATE, TICK_LIMIT,
        output SLOW_CLOCK, TICK, HALTED, TICK_COUNT
    );
`else
    modport master (
        output BUTTON, STEP_MODE, RATE,
        input  SLOW_CLOCK, TICK, HALTED, TICK_COUNT
    );

    modport slave (
        input  BUTTON, STEP_MODE, RATE,
        output SLOW_CLOCK, TICK, HALTED, TICK_COUNT
    );
`endif

endinterface

// File: rtl/button_debouncer.sv
// Synchronises a raw push button and emits a one-cycle press on each
// debounced 0->1 transition.
module button_debouncer
    import run_step_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic CLOCK,
    input  logic RESET,
    input  logic BUTTON,
    output logic press
);

    localparam logic [COUNT_W-1:0] LAST = COUNT_W'(DEBOUNCE_CYCLES - 1);

    logic               sync_q1;
    logic               sync_q2;
    logic               level_q;
    logic [COUNT_W-1:0] cnt_q;

    // Two-flop synchroniser for the asynchronous button.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= BUTTON;
            sync_q2 <= sync_q1;
        end
    end

    // Accept a new level only after it has held for the full debounce window.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            level_q <= 1'b0;
            cnt_q   <= '0;
            press   <= 1'b0;
        end else begin
            press <= 1'b0;
            if (sync_q2 == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == LAST) begin
                level_q <= sync_q2;
                cnt_q   <= '0;
                press   <= sync_q2;
            end else begin
                cnt_q <= cnt_q + COUNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/run_step_controller.sv
// Generates the slow CPU clock in free-run or single-step mode with
// full-width phases. Define STEP_LIMIT_EN to let free-run halt itself
// when TICK_COUNT reaches TICK_LIMIT.
module run_step_controller
    import run_step_pkg::*;
#(
    parameter int unsigned CLOCK_HZ         = 100_000_000,
    parameter int unsigned DEBOUNCE_CYCLES  = 1_000_000,
    parameter int unsigned STEP_HIGH_CYCLES = 10_000_000
) (
    input  logic                 CLOCK,
    input  logic                 RESET,
    run_step_controller_if.slave bus
);

    localparam logic [COUNT_W-1:0] HZ        = COUNT_W'(CLOCK_HZ);
    localparam logic [COUNT_W-1:0] STEP_LAST = COUNT_W'(STEP_HIGH_CYCLES - 1);

    state_t             state_q;
    logic [COUNT_W-1:0] cnt_q;
    logic [COUNT_W-1:0] half_q;
    logic               phase_start_q;
    logic               pause_pending_q;
    logic               slow_q;
    logic               tick_q;
    logic               halted_q;
    logic [TICK_W-1:0]  tick_count_q;

    logic               press;
    logic [COUNT_W-1:0] half_now_c;
    logic               phase_done_c;
    logic               limit_hit_c;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .BUTTON(bus.BUTTON),
        .press (press)
    );

    // The rate is sampled in the first cycle of each phase and held for the rest of it.
    assign half_now_c   = phase_start_q ? half_period(HZ, bus.RATE) : half_q;
    assign phase_done_c = (cnt_q == (half_now_c - COUNT_W'(1)));

`ifdef STEP_LIMIT_EN
    assign limit_hit_c = (bus.TICK_LIMIT != '0) && (tick_count_q == bus.TICK_LIMIT);
`else
    assign limit_hit_c = 1'b0;
`endif

    // Run/halt/step sequencing; every output is a register.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q         <= RUN_LO;
            cnt_q           <= '0;
            half_q          <= COUNT_W'(1);
            phase_start_q   <= 1'b1;
            pause_pending_q <= 1'b0;
            slow_q          <= 1'b0;
            tick_q          <= 1'b0;
            halted_q        <= 1'b0;
            tick_count_q    <= '0;
        end else begin
            tick_q        <= 1'b0;
            phase_start_q <= 1'b0;
            if (phase_start_q) begin
                half_q <= half_now_c;
            end

            case (state_q)
                RUN_LO: begin
                    if (bus.STEP_MODE || press) begin
                        state_q  <= HALT;
                        halted_q <= 1'b1;
                        cnt_q    <= '0;
                    end else if (phase_done_c) begin
                        state_q       <= RUN_HI;
                        slow_q        <= 1'b1;
                        tick_q        <= 1'b1;
                        tick_count_q  <= tick_count_q + TICK_W'(1);
                        cnt_q         <= '0;
                        phase_start_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + COUNT_W'(1);
                    end
                end

                RUN_HI: begin
                    if (phase_done_c) begin
                        slow_q          <= 1'b0;
                        cnt_q           <= '0;
                        pause_pending_q <= 1'b0;
                        if (bus.STEP_MODE || pause_pending_q || press || limit_hit_c) begin
                            state_q  <= HALT;
                            halted_q <= 1'b1;
                        end else begin
                            state_q       <= RUN_LO;
                            phase_start_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + COUNT_W'(1);
                        if (press) begin
                            pause_pending_q <= 1'b1;
                        end
                    end
                end

                HALT: begin
                    if (press) begin
                        halted_q <= 1'b0;
                        cnt_q    <= '0;
                        if (bus.STEP_MODE) begin
                            state_q      <= STEP_HI;
                            slow_q       <= 1'b1;
                            tick_q       <= 1'b1;
                            tick_count_q <= tick_count_q + TICK_W'(1);
                        end else begin
                            state_q       <= RUN_LO;
                            phase_start_q <= 1'b1;
                        end
                    end
                end

                STEP_HI: begin
                    if (cnt_q == STEP_LAST) begin
                        state_q  <= HALT;
                        slow_q   <= 1'b0;
                        halted_q <= 1'b1;
                        cnt_q    <= '0;
                    end else begin
                        cnt_q <= cnt_q + COUNT_W'(1);
                    end
                end

                default: begin
                    state_q <= HALT;
                    slow_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.SLOW_CLOCK = slow_q;
    assign bus.TICK       = tick_q;
    assign bus.HALTED     = halted_q;
    assign bus.TICK_COUNT = tick_count_q;

endmodule

// File: tb/tb_run_step_controller.sv
// Directed and randomised checks of the run/step controller with small timing parameters.
module tb_run_step_controller;
    import run_step_pkg::*;

    localparam int unsigned HZ    = 16;
    localparam int unsigned DEB   = 4;
    localparam int unsigned STEPH = 3;

    logic CLOCK = 1'b0;
    logic RESET;

    run_step_controller_if bus();

    run_step_controller #(
        .CLOCK_HZ        (HZ),
        .DEBOUNCE_CYCLES (DEB),
        .STEP_HIGH_CYCLES(STEPH)
    ) dut (
        .CLOCK(CLOCK),
        .RESET(RESET),
        .bus  (bus)
    );

    always #5 CLOCK = ~CLOCK;

    int vectors     = 0;
    int miscompares = 0;
    int exp_count   = 0;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int exp_half(input int rate);
        int h;
        h = int'(HZ >> rate) / 2;
        return (h < 1) ? 1 : h;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic measure(input logic lvl, input int start, output int len);
        len = start;
        while (bus.SLOW_CLOCK === lvl && len < 64) begin
            len++;
            step();
        end
    endtask

    task automatic check_rise(input string tag);
        exp_count++;
        check({tag, "_tick"}, 32'(bus.TICK), 32'd1);
        check({tag, "_count"}, 32'(bus.TICK_COUNT), 32'(exp_count & 32'hFFFF));
    endtask

    task automatic run_period(input string tag, input int hl, input int hh);
        int len;
        measure(1'b0, 0, len);
        check({tag, "_low"}, 32'(len), 32'(hl));
        check_rise(tag);
        measure(1'b1, 0, len);
        check({tag, "_high"}, 32'(len), 32'(hh));
        check({tag, "_tick_clear"}, 32'(bus.TICK), 32'd0);
    endtask

    task automatic wait_halted(input string tag, input logic val, input int budget);
        int n;
        n = 0;
        while (bus.HALTED !== val && n < budget) begin
            n++;
            step();
        end
        check({tag, "_halted"}, 32'(bus.HALTED), 32'(val));
    endtask

    task automatic wait_slow_high(input string tag, input int budget);
        int n;
        n = 0;
        while (bus.SLOW_CLOCK !== 1'b1 && n < budget) begin
            n++;
            step();
        end
        check({tag, "_rise_seen"}, 32'(bus.SLOW_CLOCK), 32'd1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int len;
        int rises;
        int r;
        logic exp_slow;

        RESET         = 1'b1;
        bus.BUTTON    = 1'b0;
        bus.STEP_MODE = 1'b0;
        bus.RATE      = 4'd1;
`ifdef STEP_LIMIT_EN
        bus.TICK_LIMIT = 16'd0;
`endif
        idle(2);
        check("rst_slow", 32'(bus.SLOW_CLOCK), 32'd0);
        check("rst_tick", 32'(bus.TICK), 32'd0);
        check("rst_halted", 32'(bus.HALTED), 32'd0);
        check("rst_count", 32'(bus.TICK_COUNT), 32'd0);
        RESET = 1'b0;

        // Free run at RATE=1: 4 low / 4 high.
        for (int i = 0; i < 3; i++) run_period("free", 4, 4);
        check("free_count3", 32'(bus.TICK_COUNT), 32'd3);

        // Rate change mid low phase only affects the following phase.
        step();
        bus.RATE = 4'd0;
        measure(1'b0, 1, len);
        check("midrate_low", 32'(len), 32'd4);
        check_rise("midrate");
        measure(1'b1, 0, len);
        check("midrate_high", 32'(len), 32'(exp_half(0)));

        // Random rates applied at the first cycle of each low phase.
        for (int i = 0; i < 10; i++) begin
            r = int'($urandom_range(0, 15));
            bus.RATE = 4'(r);
            run_period("rand", exp_half(r), exp_half(r));
        end

        // Minimum period: HALF clamps to one cycle.
        bus.RATE = 4'd3;
        run_period("min3", 1, 1);
        run_period("min3", 1, 1);
        bus.RATE = 4'd4;
        run_period("min4", 1, 1);
        run_period("min4", 1, 1);

        // Bouncy press landing in the high phase pauses after that phase.
        bus.RATE = 4'd1;
        for (int i = 0; i < 16; i++) begin
            bus.BUTTON = (i < 6) ? ((i % 2) == 0) : 1'b1;
            exp_slow = ((i / 4) % 2) == 1;
            check("pause_wave", 32'(bus.SLOW_CLOCK), 32'(exp_slow));
            step();
        end
        bus.BUTTON = 1'b0;
        exp_count += 2;
        check("pause_count", 32'(bus.TICK_COUNT), 32'(exp_count & 32'hFFFF));
        check("pause_halted", 32'(bus.HALTED), 32'd1);
        check("pause_slow", 32'(bus.SLOW_CLOCK), 32'd0);
        idle(20);
        check("pause_hold", 32'(bus.HALTED), 32'd1);

        // Mode switch alone keeps the controller halted.
        bus.STEP_MODE = 1'b1;
        idle(3);
        bus.STEP_MODE = 1'b0;
        idle(3);
        check("mode_nohalt_exit", 32'(bus.HALTED), 32'd1);
        check("mode_nohalt_count", 32'(bus.TICK_COUNT), 32'(exp_count & 32'hFFFF));

        // Clean press resumes with a full low phase.
        bus.BUTTON = 1'b1;
        wait_halted("resume", 1'b0, 20);
        bus.BUTTON = 1'b0;
        run_period("resume", 4, 4);

        // Single step: one press, one 3-cycle pulse, button held throughout.
        bus.STEP_MODE = 1'b1;
        wait_halted("enter_step", 1'b1, 10);
        idle(10);
        bus.BUTTON = 1'b1;
        wait_slow_high("step1", 20);
        check_rise("step1");
        measure(1'b1, 0, len);
        check("step1_high", 32'(len), 32'(STEPH));
        check("step1_halted", 32'(bus.HALTED), 32'd1);
        idle(10);
        check("step1_single", 32'(bus.TICK_COUNT), 32'(exp_count & 32'hFFFF));
        bus.BUTTON = 1'b0;
        idle(10);

        // Second step with the button bouncing during the pulse.
        bus.BUTTON = 1'b1;
        wait_slow_high("step2", 20);
        check_rise("step2");
        len = 0;
        while (bus.SLOW_CLOCK === 1'b1 && len < 64) begin
            bus.BUTTON = ~bus.BUTTON;
            len++;
            step();
        end
        bus.BUTTON = 1'b0;
        check("step2_high", 32'(len), 32'(STEPH));
        rises = 0;
        for (int i = 0; i < 15; i++) begin
            if (bus.TICK === 1'b1) rises++;
            step();
        end
        check("step2_no_extra", 32'(rises), 32'd0);
        check("step2_halted", 32'(bus.HALTED), 32'd1);

        // Asynchronous reset in the middle of a high phase.
        bus.STEP_MODE = 1'b0;
        idle(3);
        bus.BUTTON = 1'b1;
        wait_halted("rst_resume", 1'b0, 20);
        bus.BUTTON = 1'b0;
        wait_slow_high("rst_mid", 20);
        check_rise("rst_mid");
        step();
        RESET = 1'b1;
        #1;
        check("async_slow", 32'(bus.SLOW_CLOCK), 32'd0);
        check("async_count", 32'(bus.TICK_COUNT), 32'd0);
        check("async_halted", 32'(bus.HALTED), 32'd0);
        exp_count = 0;
        step();
        RESET = 1'b0;
        run_period("after_rst", 4, 4);
        run_period("after_rst", 4, 4);

`ifdef STEP_LIMIT_EN
        // Tick limit halts free run after the limit-th high phase.
        RESET = 1'b1;
        bus.TICK_LIMIT = 16'd2;
        bus.RATE = 4'd1;
        step();
        RESET = 1'b0;
        exp_count = 0;
        run_period("limit", 4, 4);
        run_period("limit", 4, 4);
        check("limit_halted", 32'(bus.HALTED), 32'd1);
        idle(20);
        check("limit_hold_count", 32'(bus.TICK_COUNT), 32'd2);
        bus.BUTTON = 1'b1;
        wait_halted("limit_resume", 1'b0, 20);
        bus.BUTTON = 1'b0;
        run_period("limit_resume", 4, 4);
        check("limit_no_rehit", 32'(bus.HALTED), 32'd0);

        RESET = 1'b1;
        bus.TICK_LIMIT = 16'd0;
        step();
        RESET = 1'b0;
        exp_count = 0;
        for (int i = 0; i < 4; i++) run_period("nolimit", 4, 4);
        check("nolimit_running", 32'(bus.HALTED), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
